tx_frame_arbiter: RTL and testbench

Two-input frame arbiter that shares the single 32-bit Ethernet TX write port (flags/data/src_rdy/dst_rdy) between two frame generators, such as two packet senders. Arbitration is round-robin and happens only at frame boundaries, so frames are never interleaved. After each frame the arbiter enforces a programmable inter-frame idle gap. Beats that arrive outside a frame are flushed and counted.

---
 rtl/tx_frame_arbiter.sv | 150 +++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Two-input frame arbiter for a 32-bit TX write port: round-robin grant at frame
// boundaries, programmable inter-frame gap, and flushing of out-of-frame beats.
module tx_frame_arbiter #(
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  in0_flags,
  input  logic [31:0] in0_data,
  input  logic        in0_src_rdy,
  output logic        in0_dst_rdy,
  input  logic [3:0]  in1_flags,
  input  logic [31:0] in1_data,
  input  logic        in1_src_rdy,
  output logic        in1_dst_rdy,
  output logic [3:0]  out_flags,
  output logic [31:0] out_data,
  output logic        out_src_rdy,
  input  logic        out_dst_rdy,
  output logic        busy,
  output logic [15:0] frames0,
  output logic [15:0] frames1,
  output logic [15:0] drop_count
);

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GAP_W   = 8;
  localparam logic        IFG_ZERO = (IFG_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_grant;
  logic               w_grant_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               r_busy;
  logic [CNT_W-1:0]   r_frames0;
  logic [CNT_W-1:0]   r_frames1;
  logic [CNT_W-1:0]   r_drops;

  logic               w_req0;
  logic               w_req1;
  logic               w_in_pass;
  logic [FLAGS_W-1:0] w_sel_flags;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_src_rdy;
  logic               w_own0;
  logic               w_own1;
  logic               w_flush0;
  logic               w_flush1;
  logic               w_eof_xfer;

  assign w_req0        = in0_src_rdy & in0_flags[0];
  assign w_req1        = in1_src_rdy & in1_flags[0];
  assign w_in_pass     = (r_state == ST_PASS);
  assign w_sel_flags   = r_grant ? in1_flags   : in0_flags;
  assign w_sel_data    = r_grant ? in1_data    : in0_data;
  assign w_sel_src_rdy = r_grant ? in1_src_rdy : in0_src_rdy;
  assign w_own0        = w_in_pass & ~r_grant;
  assign w_own1        = w_in_pass &  r_grant;

  // Any port not currently streaming has its non-SOF beats accepted and discarded
  assign w_flush0   = in0_src_rdy & ~in0_flags[0] & ~w_own0;
  assign w_flush1   = in1_src_rdy & ~in1_flags[0] & ~w_own1;
  assign w_eof_xfer = w_in_pass & w_sel_src_rdy & out_dst_rdy & w_sel_flags[1];

  assign out_flags   = w_in_pass ? w_sel_flags : '0;
  assign out_data    = w_in_pass ? w_sel_data  : '0;
  assign out_src_rdy = w_in_pass & w_sel_src_rdy;
  assign in0_dst_rdy = w_own0 ? out_dst_rdy : w_flush0;
  assign in1_dst_rdy = w_own1 ? out_dst_rdy : w_flush1;

  assign busy       = r_busy;
  assign frames0    = r_frames0;
  assign frames1    = r_frames1;
  assign drop_count = r_drops;

  // Next-state: grant only from IDLE, release on EOF, count down the gap
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_grant_nxt = ~r_last;
          w_state_nxt = ST_PASS;
        end else if (w_req0) begin
          w_grant_nxt = 1'b0;
          w_state_nxt = ST_PASS;
        end else if (w_req1) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        if (w_eof_xfer) begin
          w_last_nxt  = r_grant;
          w_gap_nxt   = GAP_W'(IFG_CYCLES);
          w_state_nxt = IFG_ZERO ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt   = r_gap - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_gap     <= '0;
      r_busy    <= 1'b0;
      r_frames0 <= '0;
      r_frames1 <= '0;
      r_drops   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_gap     <= w_gap_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_frames0 <= r_frames0 + CNT_W'(w_eof_xfer & ~r_grant);
      r_frames1 <= r_frames1 + CNT_W'(w_eof_xfer &  r_grant);
      r_drops   <= r_drops + CNT_W'(w_flush0) + CNT_W'(w_flush1);
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed scenarios plus randomized traffic, checked by
// a scoreboard whose arbitration/gap model is kept at frame level.
module tb_tx_frame_arbiter;

  localparam int unsigned IFG     = 2;
  localparam int unsigned TIMEOUT = 200;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  d_flags [2];
  logic [31:0] d_data  [2];
  logic        d_src   [2];
  logic        in0_dst_rdy, in1_dst_rdy;
  logic [3:0]  out_flags;
  logic [31:0] out_data;
  logic        out_src_rdy, out_dst_rdy;
  logic        busy;
  logic [15:0] frames0, frames1, drop_count;

  logic [3:0]  b_flags0, b_flags1;
  logic [31:0] b_data0, b_data1;
  logic        b_src0, b_src1, b_dst0, b_dst1;
  logic [3:0]  b_out_flags;
  logic [31:0] b_out_data;
  logic        b_out_src_rdy, b_out_dst_rdy, b_busy;
  logic [15:0] b_frames0, b_frames1, b_drops;

  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    rnd_run = 1'b0;
  bit    t3_done = 1'b0;
  int    t3_k;
  logic  pat [4];

  beat_t sbq0[$];
  beat_t sbq1[$];
  int    grant_log[$];
  int    owner = -1;
  int    gap_left = 0;
  int    last_m = 1;
  int    g_exp;
  logic  prev_req [2];
  int    exp_frames [2];
  int    exp_drops = 0;
  beat_t e_beat;
  bit    e_ok;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.IFG_CYCLES(IFG)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .in0_flags(d_flags[0]), .in0_data(d_data[0]), .in0_src_rdy(d_src[0]), .in0_dst_rdy(in0_dst_rdy),
    .in1_flags(d_flags[1]), .in1_data(d_data[1]), .in1_src_rdy(d_src[1]), .in1_dst_rdy(in1_dst_rdy),
    .out_flags(out_flags), .out_data(out_data), .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .busy(busy), .frames0(frames0), .frames1(frames1), .drop_count(drop_count)
  );

  tx_frame_arbiter #(.IFG_CYCLES(0)) u_dut_nogap (
    .clk(clk), .reset_n(reset_n),
    .in0_flags(b_flags0), .in0_data(b_data0), .in0_src_rdy(b_src0), .in0_dst_rdy(b_dst0),
    .in1_flags(b_flags1), .in1_data(b_data1), .in1_src_rdy(b_src1), .in1_dst_rdy(b_dst1),
    .out_flags(b_out_flags), .out_data(b_out_data), .out_src_rdy(b_out_src_rdy),
    .out_dst_rdy(b_out_dst_rdy),
    .busy(b_busy), .frames0(b_frames0), .frames1(b_frames1), .drop_count(b_drops)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic dst_of(input int p);
    return (p == 0) ? in0_dst_rdy : in1_dst_rdy;
  endfunction

  task automatic drive(input int p, input logic [3:0] f, input logic [31:0] d, input logic v);
    d_flags[p] = f;
    d_data[p]  = d;
    d_src[p]   = v;
  endtask

  // Present one beat and hold it until the handshake edge; returns just after that edge
  task automatic send_beat(input int p, input logic [3:0] f, input logic [31:0] d);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    drive(p, f, d, 1'b1);
    while (!done) begin
      @(negedge clk);
      if (dst_of(p)) begin
        done = 1'b1;
      end else if (n >= int'(TIMEOUT)) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout port%0d: no dst_rdy after %0d cycles, required 1", p, n);
        done = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int p, input int len, input bit rnd, input bit stall);
    logic [3:0]  f;
    logic [31:0] d;
    int          k;
    for (int i = 0; i < len; i++) begin
      f[0]   = (i == 0);
      f[1]   = (i == len - 1);
      f[3:2] = (rnd && i == len - 1) ? 2'($urandom) : 2'b00;
      d      = rnd ? $urandom : 32'hA + 32'(i);
      if (p == 0) sbq0.push_back('{f: f, d: d});
      else        sbq1.push_back('{f: f, d: d});
      if (stall && i > 0) begin
        k = int'($urandom_range(0, 2));
        if (k > 0) begin
          d_src[p] = 1'b0;
          repeat (k) @(posedge clk);
          #1;
        end
      end
      send_beat(p, f, d);
    end
    d_src[p] = 1'b0;
    exp_frames[p]++;
  endtask

  // An orphan must be swallowed in the very cycle it is presented
  task automatic send_orphan(input int p, input logic [3:0] f, input logic [31:0] d);
    drive(p, f, d, 1'b1);
    @(negedge clk);
    chk($sformatf("orphan_dst_rdy_p%0d", p), 64'(dst_of(p)), 64'(1));
    exp_drops++;
    @(posedge clk);
    #1;
    d_src[p] = 1'b0;
  endtask

  task automatic model_clear();
    owner    = -1;
    gap_left = 0;
    last_m   = 1;
    sbq0.delete();
    sbq1.delete();
    grant_log.delete();
    exp_frames[0] = 0;
    exp_frames[1] = 0;
    exp_drops = 0;
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    d_src[0] = 1'b0;
    d_src[1] = 1'b0;
    #1;
    chk("rst_out_src_rdy", 64'(out_src_rdy), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frames0", 64'(frames0), 64'(0));
    chk("rst_frames1", 64'(frames1), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    chk("rst_dst_rdy0", 64'(in0_dst_rdy), 64'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Monitor: frame-level arbitration and gap model plus per-port in-order scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (gap_left > 0) begin
        chk("gap_src_rdy", 64'(out_src_rdy), 64'(0));
        chk("gap_busy", 64'(busy), 64'(gap_left > 1));
        gap_left--;
      end else if (owner < 0) begin
        if (out_src_rdy) begin
          if (prev_req[0] && prev_req[1]) g_exp = 1 - last_m;
          else if (prev_req[0])           g_exp = 0;
          else if (prev_req[1])           g_exp = 1;
          else begin
            g_exp = 0;
            checks++;
            errors++;
            $display("FAIL grant_without_request: got out_src_rdy 1 expected 0 at %0t", $time);
          end
          owner = g_exp;
          grant_log.push_back(g_exp);
        end else begin
          chk("idle_busy", 64'(busy), 64'(0));
          chk("idle_out_flags", 64'(out_flags), 64'(0));
          chk("idle_out_data", 64'(out_data), 64'(0));
        end
      end
      if (owner >= 0) begin
        chk("pass_busy", 64'(busy), 64'(1));
        chk("pass_src_rdy", 64'(out_src_rdy), 64'(d_src[owner]));
        chk("pass_dst_rdy", 64'(dst_of(owner)), 64'(out_dst_rdy));
        if (out_src_rdy && out_dst_rdy) begin
          e_ok = 1'b1;
          if (owner == 0 && sbq0.size() > 0)      e_beat = sbq0.pop_front();
          else if (owner == 1 && sbq1.size() > 0) e_beat = sbq1.pop_front();
          else begin
            e_ok = 1'b0;
            checks++;
            errors++;
            $display("FAIL unexpected_beat port%0d: got %0h expected none", owner, out_data);
          end
          if (e_ok) begin
            chk($sformatf("beat_p%0d", owner), 64'({out_flags, out_data}),
                64'({e_beat.f, e_beat.d}));
            if (e_beat.f[1]) begin
              last_m   = owner;
              owner    = -1;
              gap_left = int'(IFG) + 1;
            end
          end
        end
      end
    end
    prev_req[0] = d_src[0] & d_flags[0][0];
    prev_req[1] = d_src[1] & d_flags[1][0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int p = 0; p < 2; p++) drive(p, 4'b0000, 32'h0, 1'b0);
    out_dst_rdy = 1'b1;
    b_flags0 = '0; b_data0 = '0; b_src0 = 1'b0;
    b_flags1 = '0; b_data1 = '0; b_src1 = 1'b0;
    b_out_dst_rdy = 1'b1;
    prev_req[0] = 1'b0;
    prev_req[1] = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single 3-word frame: exact cycle timing including gap and idle
    fork
      send_frame(0, 3, 1'b0, 1'b0);
      begin
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          chk($sformatf("t1_src_rdy_c%0d", c), 64'(out_src_rdy), 64'(c >= 1 && c <= 3));
          if (c >= 1 && c <= 3) chk($sformatf("t1_data_c%0d", c), 64'(out_data), 64'(32'hA + 32'(c - 1)));
        end
      end
    join
    chk("t1_frames0", 64'(frames0), 64'(1));

    // Simultaneous SOFs after reset: grants alternate starting with port 0
    do_reset();
    fork
      repeat (2) send_frame(0, int'($urandom_range(1, 4)), 1'b1, 1'b0);
      repeat (2) send_frame(1, int'($urandom_range(1, 4)), 1'b1, 1'b0);
    join
    chk("t2_grants", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk($sformatf("t2_order_%0d", i), 64'(grant_log[i]), 64'(i % 2));
    chk("t2_frames0", 64'(frames0), 64'(2));
    chk("t2_frames1", 64'(frames1), 64'(2));

    // Backpressure pattern 1,0,0,1 repeated across a frame
    t3_done = 1'b0;
    t3_k = 0;
    fork
      begin send_frame(0, 5, 1'b1, 1'b0); t3_done = 1'b1; end
      while (!t3_done) begin
        out_dst_rdy = pat[t3_k % 4];
        t3_k++;
        @(posedge clk);
        #1;
      end
    join
    out_dst_rdy = 1'b1;

    // Orphan on port 1 while port 0 streams
    fork
      send_frame(0, 4, 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_orphan(1, 4'b0000, 32'h55);
      end
    join
    chk("t4_drop_count", 64'(drop_count), 64'(1));

    // Reset mid-frame: outputs clear at once, tail beats become orphans
    mon_en = 1'b0;
    repeat (IFG + 2) @(posedge clk);
    #1;
    send_beat(0, 4'b0001, 32'h1);
    drive(0, 4'b0000, 32'h2, 1'b1);
    #1;
    chk("t5_mid_src_rdy", 64'(out_src_rdy), 64'(1));
    chk("t5_mid_data", 64'(out_data), 64'(32'h2));
    reset_n = 1'b0;
    d_src[0] = 1'b0;
    #1;
    chk("t5_rst_src_rdy", 64'(out_src_rdy), 64'(0));
    chk("t5_rst_data", 64'(out_data), 64'(0));
    chk("t5_rst_frames0", 64'(frames0), 64'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_orphan(0, 4'b0000, 32'h2);
    send_orphan(0, 4'b0010, 32'h3);
    chk("t5_drop_count", 64'(drop_count), 64'(2));
    chk("t5_frames0", 64'(frames0), 64'(0));
    mon_en = 1'b1;

    // Zero-gap instance: single-beat frames on port 1 every 2 cycles
    for (int k = 0; k < 5; k++) begin
      b_flags1 = 4'b0011;
      b_data1  = 32'h100 + 32'(k);
      b_src1   = 1'b1;
      @(negedge clk);
      chk($sformatf("t6_idle_c%0d", k), 64'(b_out_src_rdy), 64'(0));
      @(negedge clk);
      chk($sformatf("t6_valid_c%0d", k), 64'(b_out_src_rdy), 64'(1));
      chk($sformatf("t6_data_c%0d", k), 64'(b_out_data), 64'(32'h100 + 32'(k)));
      chk($sformatf("t6_dst_rdy_c%0d", k), 64'(b_dst1), 64'(1));
      @(posedge clk);
      #1;
      chk($sformatf("t6_frames1_c%0d", k), 64'(b_frames1), 64'(k + 1));
    end
    b_src1 = 1'b0;

    // Randomized traffic on both ports with random backpressure
    rnd_run = 1'b1;
    fork
      begin
        fork
          for (int it = 0; it < 15; it++) begin
            d_src[0] = 1'b0;
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0)
              send_orphan(0, {2'($urandom), 1'($urandom), 1'b0}, $urandom);
            else
              send_frame(0, int'($urandom_range(1, 4)), 1'b1, 1'b1);
          end
          for (int it = 0; it < 15; it++) begin
            d_src[1] = 1'b0;
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0)
              send_orphan(1, {2'($urandom), 1'($urandom), 1'b0}, $urandom);
            else
              send_frame(1, int'($urandom_range(1, 4)), 1'b1, 1'b1);
          end
        join
        rnd_run = 1'b0;
      end
      while (rnd_run) begin
        out_dst_rdy = ($urandom_range(0, 9) < 7);
        @(posedge clk);
        #1;
      end
    join
    out_dst_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("end_sbq0_empty", 64'(sbq0.size()), 64'(0));
    chk("end_sbq1_empty", 64'(sbq1.size()), 64'(0));
    chk("end_frames0", 64'(frames0), 64'(exp_frames[0]));
    chk("end_frames1", 64'(frames1), 64'(exp_frames[1]));
    chk("end_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("end_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
